// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared state encoding, protocol byte constants and default clocking
// for the FIFO-to-UART transmitter. The PARITY state exists only when
// FIFO_UART_TX_PARITY_EN is defined (8E1); otherwise the framing is 8N1.
package fifo_uart_pkg;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 115_200;

    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] END_MARK = 8'hCC;

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        LATCH  = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        LATCH  = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        STOP   = 3'd6
    } state_t;
`endif

endpackage

// File: rtl/fifo_uart_tx_baud_cnt.sv
// uart_baud_cnt: reloadable bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps;
// clear forces the next count to 0 so every FSM state starts a fresh bit period.
// bit_end is high during the last cycle of each bit period.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Bit-period counter: reload on clear, wrap at the last cycle of the bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a normal-mode (1-cycle read latency) byte FIFO and sends each
// byte on a UART line, LSB first, one stop bit. Define FIFO_UART_TX_PARITY_EN to add an
// even parity bit (8E1). All outputs are registered; the FSM looks one state ahead so
// tx/rdreq/busy change exactly on the state boundaries.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
    parameter int BAUD         = DEFAULT_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       empty,
    input  logic [7:0] q,
    output logic       rdreq,
    output logic       tx,
    output logic       busy,
    output logic       byte_done,
    output logic       frame_done
);

    state_t     state;
    state_t     next_state;
    logic       bit_end;
    logic       clear;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic [7:0] shift_next;
    logic [7:0] last_byte;
    logic       prev_cr;
    logic       byte_end;
    logic       tx_next;
    logic       rdreq_next;
    logic       busy_next;

    // The baud counter restarts whenever the FSM changes state
    assign clear    = (next_state != state);
    assign byte_end = (state == STOP) && bit_end;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (clear),
        .bit_end(bit_end)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; empty and enable only matter in IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (enable && !empty) next_state = REQ;
            REQ:   next_state = LATCH;
            LATCH: next_state = START;
            START: if (bit_end) next_state = DATA;
`ifdef FIFO_UART_TX_PARITY_EN
            DATA:   if (bit_end && (bit_idx == 3'd7)) next_state = PARITY;
            PARITY: if (bit_end) next_state = STOP;
`else
            DATA:   if (bit_end && (bit_idx == 3'd7)) next_state = STOP;
`endif
            STOP:  if (bit_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode for the upcoming cycle, so the registered outputs line up with states
    always_comb begin
        shift_next = shift;
        if (state == LATCH) begin
            shift_next = q;
        end else if ((state == DATA) && bit_end) begin
            shift_next = {1'b0, shift[7:1]};
        end

        rdreq_next = (next_state == REQ);
        busy_next  = (next_state != IDLE);

        case (next_state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_next = ^last_byte;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    // Data bit index within the DATA state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_idx <= '0;
        end else if (state != DATA) begin
            bit_idx <= '0;
        end else if (bit_end) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // Byte datapath: shift register and a copy of the byte in flight (no reset needed)
    always_ff @(posedge clk) begin
        shift <= shift_next;
        if (state == LATCH) begin
            last_byte <= q;
        end
    end

    // Registered outputs and CR/LF frame tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx         <= 1'b1;
            rdreq      <= 1'b0;
            busy       <= 1'b0;
            byte_done  <= 1'b0;
            frame_done <= 1'b0;
            prev_cr    <= 1'b0;
        end else begin
            tx         <= tx_next;
            rdreq      <= rdreq_next;
            busy       <= busy_next;
            byte_done  <= byte_end;
            frame_done <= byte_end && prev_cr && (last_byte == LF);
            if (byte_end) begin
                prev_cr <= (last_byte == CR);
            end
        end
    end

endmodule
